ram_scanout: RTL and testbench
==============================

RAM_SCANOUT -- requirements
Module: ram_scanout

Interface
REQ-001 Parameter: ram_width, default 8, address width of the pixel RAM read port.
REQ-002 Parameter: data_width, default 12, pixel word width.
REQ-003 rd_clk  input  1  sole clock, same clock as the RAM read port; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 base_add  input  ram_width  first RAM address of the burst; captured with start.
REQ-007 length  input  ram_width+1  pixel count of the burst, 0..2^ram_width; captured with start.
REQ-008 rd_add  output  ram_width  RAM read address.
REQ-009 rd_data  input  data_width  RAM registered read data, valid one cycle after rd_add is presented.
REQ-010 m_data  output  data_width  output pixel.
REQ-011 m_valid  output  1  m_data valid.
REQ-012 m_ready  input  1  downstream accepts; transfer occurs when m_valid and m_ready are both high.
REQ-013 m_last  output  1  high with the final pixel of the burst.
REQ-014 m_invalid  output  1  high when m_data equals 0 (not-valid pixel marker); the pixel is still delivered.
REQ-015 busy  output  1  high from the cycle after start is accepted until done.
REQ-016 done  output  1  one-cycle pulse at burst completion.

Function
REQ-017 States: IDLE, RUN (issuing reads), DRAIN (all reads issued, output FIFO not empty).
REQ-018 IDLE -> RUN on start with length != 0; IDLE with start and length == 0 -> done pulse next cycle, stays IDLE, busy stays 0.
REQ-019 Output buffering: 2-entry FIFO holding {pixel, last}; m_valid = FIFO not empty; m_data/m_last/m_invalid from FIFO head.
REQ-020 Read issue: one read per cycle in RUN when (fifo_count + inflight - pop) < 2, where inflight is 1 if a read was issued the previous cycle and pop is this cycle's transfer.
REQ-021 A read issued in cycle t is written into the FIFO at the end of cycle t+1 from rd_data; no RAM data is ever dropped or duplicated.
REQ-022 rd_add holds its last value when no read is issued; it increments by 1 per issued read, modulo 2^ram_width (255 -> 0 wrap with default width).
REQ-023 Latency: with m_ready high, first m_valid asserts exactly 3 cycles after the cycle start is sampled; sustained throughput 1 pixel/cycle.
REQ-024 Under m_ready low, m_data/m_last/m_invalid hold stable while m_valid is high; reads stall so no more than 2 pixels are buffered.
REQ-025 m_last is set on the entry for the length-th issued read only.
REQ-026 RUN -> DRAIN when the length-th read is issued; DRAIN -> IDLE on transfer of the m_last pixel; done pulses and busy clears in the cycle after that transfer.
REQ-027 start while busy is ignored; base_add/length changes during a burst have no effect.
REQ-028 m_invalid is combinational on FIFO head: 1 if m_data == 0, else 0.

Reset
REQ-029 rst high at a rising edge forces, on the next cycle: state IDLE, FIFO empty, inflight 0, rd_add 0, m_valid 0, m_last 0, m_invalid 0, busy 0, done 0.
REQ-030 Reset mid-burst aborts it with no done pulse; rd_data returned after reset is discarded.

Verification
RAM image for all scenarios: mem[i]=i, except mem[0]=0x00A and mem[4]=mem[51]=mem[53]=mem[103]=0.
REQ-031 start, base_add=0, length=8, m_ready=1 -> m_valid 3 cycles later, data 00A,001,002,003,000,005,006,007 on consecutive cycles; m_invalid only on 5th; m_last on 007; done 1 cycle later.
REQ-032 base_add=250, length=10 -> data 0FA..0FF,00A,001,002,003; rd_add wraps 255 -> 0.
REQ-033 base_add=50, length=6, m_ready toggling 1,0,0,1 repeating -> exact sequence 032,000,034,000,036,037, no loss/duplication, at most 2 buffered, m_invalid on 2nd and 4th.
REQ-034 start with length=0 -> done pulse next cycle, m_valid never asserted, busy stays 0.
REQ-035 start during a burst (base_add=100) -> ignored, original burst completes unchanged.
REQ-036 rst asserted after 3 pixels of a length=20 burst -> next cycle m_valid=0, busy=0, no done; fresh start base_add=100, length=4 -> 064,065,066,000.

Source files
------------

// File: rtl/ram_scanout.sv
// rtl/ram_scanout.sv - burst reader from a registered-output pixel RAM into a 2-deep handshake stream
module ram_scanout #(
    parameter int ram_width  = 8,
    parameter int data_width = 12
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ram_width-1:0]  base_add,
    input  logic [ram_width:0]    length,
    output logic [ram_width-1:0]  rd_add,
    input  logic [data_width-1:0] rd_data,
    output logic [data_width-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  m_invalid,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    logic [data_width-1:0] fifo_data [2];
    logic                  fifo_last [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_count;
    logic                  inflight;
    logic                  inflight_last;
    logic [ram_width:0]    remaining;
    logic                  pop;
    logic                  push;
    logic                  issue;

    assign m_valid   = (fifo_count != 2'd0);
    assign m_data    = fifo_data[rd_ptr];
    assign m_last    = m_valid && fifo_last[rd_ptr];
    assign m_invalid = m_valid && (m_data == '0);

    assign pop  = m_valid && m_ready;
    assign push = inflight;
    // Reserve a FIFO slot for the read still in the RAM pipeline so nothing is ever dropped.
    assign issue = (state == RUN) &&
                   (({1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop}) < 3'd2);

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            fifo_count    <= 2'd0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            rd_add        <= '0;
            remaining     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            done <= 1'b0;

            if (push) begin
                fifo_data[wr_ptr] <= rd_data;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + 2'(push) - 2'(pop);

            inflight      <= issue;
            inflight_last <= issue && (remaining == (ram_width+1)'(1));
            if (issue) begin
                rd_add    <= rd_add + ram_width'(1);
                remaining <= remaining - (ram_width+1)'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            state     <= RUN;
                            rd_add    <= base_add;
                            remaining <= length;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue && (remaining == (ram_width+1)'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_scanout.sv
// tb/tb_ram_scanout.sv - directed scoreboard bench for ram_scanout
module tb_ram_scanout;
    localparam int AW = 8;
    localparam int DW = 12;

    logic          rd_clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_add;
    logic [AW:0]   length;
    logic [AW-1:0] rd_add;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          m_invalid;
    logic          busy;
    logic          done;

    ram_scanout #(.ram_width(AW), .data_width(DW)) dut (
        .rd_clk(rd_clk), .rst(rst), .start(start), .base_add(base_add), .length(length),
        .rd_add(rd_add), .rd_data(rd_data), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .m_invalid(m_invalid), .busy(busy), .done(done)
    );

    always #5 rd_clk = ~rd_clk;

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        if (a == 0) return 12'h00A;
        if (a == 4 || a == 51 || a == 53 || a == 103) return '0;
        return DW'(a);
    endfunction

    always @(posedge rd_clk) rd_data <= mem(rd_add);

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t          sb[$];
    int            n_assert = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            xfers = 0;
    int            issued = 0;
    int            done_cnt = 0;
    int            done_cyc = -1;
    int            last_cyc = -1;
    int            first_valid = -1;
    logic [AW-1:0] prev_add = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, drive m_ready for it, then score whatever transfers at the next edge.
    task automatic tick(input logic rdy);
        exp_t e;
        @(posedge rd_clk);
        #1;
        cyc++;
        m_ready = rdy;
        if (rd_add != prev_add) issued++;
        prev_add = rd_add;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (busy) chk("buffered_le_2", (issued - xfers) <= 2, 1'b1);
        if (m_valid && m_ready) begin
            chk("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("m_data", m_data, e.d);
                chk("m_last", m_last, e.l);
                chk("m_invalid", m_invalid, e.d == '0);
                if (m_last) last_cyc = cyc;
            end
            xfers++;
        end
    endtask

    task automatic burst(input int base, input int len, input int mode, input int inject_at);
        int c0;
        for (int i = 0; i < len; i++) sb.push_back('{mem(AW'(base + i)), (i == len - 1)});
        done_cnt = 0; done_cyc = -1; last_cyc = -1; first_valid = -1;
        prev_add = AW'(base); issued = 0; xfers = 0;
        c0 = cyc;
        base_add = AW'(base);
        length = (AW+1)'(len);
        start = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick(mode == 0 ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3)));
            start = (k == inject_at);
            if (k == inject_at) begin
                base_add = 8'd100;
                length = 9'd5;
            end
            if (k == 0) chk("busy_after_start", busy, len != 0);
            if (sb.size() == 0 && done_cnt > 0) break;
        end
        start = 1'b0;
        for (int j = 0; j < 3; j++) tick(1'b1);
        chk("sb_drained", sb.size(), 0);
        chk("done_count", done_cnt, 1);
        chk("busy_end", busy, 1'b0);
        if (len != 0) begin
            chk("rd_add_end", rd_add, AW'(base + len));
            chk("done_after_last", done_cyc, last_cyc + 1);
            if (mode == 0) begin
                chk("first_valid_latency", first_valid, c0 + 3);
                chk("throughput", last_cyc - first_valid, len - 1);
            end
        end else begin
            chk("done_len0", done_cyc, c0 + 1);
            chk("no_valid_len0", first_valid, -1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; m_ready = 1'b1; base_add = '0; length = '0;
        tick(1'b1);
        tick(1'b1);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_m_invalid", m_invalid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_add", rd_add, 0);
        rst = 1'b0;
        tick(1'b1);

        burst(0, 8, 0, -1);
        burst(250, 10, 0, -1);
        burst(50, 6, 1, -1);
        burst(0, 0, 0, -1);
        burst(0, 8, 0, 3);

        for (int i = 0; i < 20; i++) sb.push_back('{mem(AW'(i)), (i == 19)});
        prev_add = '0; issued = 0; xfers = 0; done_cnt = 0;
        base_add = '0; length = 9'd20; start = 1'b1;
        for (int k = 0; k < 50 && xfers < 3; k++) begin
            tick(1'b1);
            start = 1'b0;
        end
        chk("three_xfers", xfers, 3);
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        chk("abort_m_valid", m_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_rd_add", rd_add, 0);
        sb.delete();
        for (int j = 0; j < 5; j++) tick(1'b1);
        chk("no_done_after_abort", done_cnt, 0);
        chk("no_valid_after_abort", m_valid, 1'b0);

        burst(100, 4, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
